// File: rtl/demux2_8_buf_if.sv
// Bus bundle for the buffered 1-to-2 byte demultiplexer: one valid/ready input,
// two valid/ready outputs and the per-channel status/debug signals.
interface demux2_8_buf_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [7:0]       out1_data;
  logic             out1_valid;
  logic             out1_ready;

  logic [7:0]       out2_data;
  logic             out2_valid;
  logic             out2_ready;

  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;
  logic             full1;
  logic             full2;

  // Producer/sink side (testbench or surrounding datapath).
  modport master (
    output in_data, in_sel, in_valid, out1_ready, out2_ready,
    input  in_ready, out1_data, out1_valid, out2_data, out2_valid,
    input  cnt1, cnt2, full1, full2
  );

  // Demultiplexer side.
  modport slave (
    input  in_data, in_sel, in_valid, out1_ready, out2_ready,
    output in_ready, out1_data, out1_valid, out2_data, out2_valid,
    output cnt1, cnt2, full1, full2
  );
endinterface

// File: rtl/demux2_8_buf.sv
// Buffered 1-to-2 byte demultiplexer: each input beat is steered by in_sel into
// one of two independent 2-entry FIFOs, each with a delivered-beat counter.
module demux2_8_buf #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst,
  demux2_8_buf_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  logic [1:0]            ch_ready;
  logic [1:0]            ch_valid;
  logic [1:0]            ch_full;
  logic [1:0]            ch_push;
  logic [1:0][7:0]       ch_data;
  logic [1:0][CNT_W-1:0] ch_cnt;
  logic                  in_ready;

  assign ch_ready = {bus.out2_ready, bus.out1_ready};

  // Space check uses registered occupancy only, so a same-cycle pop never
  // opens a slot for a push; reset blocks the handshake entirely.
  assign in_ready = ~rst & ~ch_full[bus.in_sel];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      state_t           state_reg, state_next;
      logic             wr_ptr_reg, wr_ptr_next;
      logic             rd_ptr_reg, rd_ptr_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic [7:0]       mem_reg [DEPTH];
      logic             pop;

      assign ch_push[gi] = bus.in_valid & in_ready & (bus.in_sel == 1'(gi));
      assign pop         = (state_reg != EMPTY) & ch_ready[gi];

      always_comb begin
        state_next  = state_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        cnt_next    = cnt_reg;

        case (state_reg)
          EMPTY: begin
            if (ch_push[gi]) state_next = ONE;
          end
          ONE: begin
            if (ch_push[gi] && !pop)      state_next = TWO;
            else if (!ch_push[gi] && pop) state_next = EMPTY;
          end
          TWO: begin
            if (pop) state_next = ONE;
          end
          default: state_next = EMPTY;
        endcase

        if (ch_push[gi]) wr_ptr_next = ~wr_ptr_reg;
        if (pop) begin
          rd_ptr_next = ~rd_ptr_reg;
          cnt_next    = cnt_reg + CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg  <= EMPTY;
          wr_ptr_reg <= 1'b0;
          rd_ptr_reg <= 1'b0;
          cnt_reg    <= '0;
          for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= 8'h00;
          end
        end else begin
          state_reg  <= state_next;
          wr_ptr_reg <= wr_ptr_next;
          rd_ptr_reg <= rd_ptr_next;
          cnt_reg    <= cnt_next;
          if (ch_push[gi]) begin
            mem_reg[wr_ptr_reg] <= bus.in_data;
          end
        end
      end

      assign ch_valid[gi] = (state_reg != EMPTY);
      assign ch_full[gi]  = (state_reg == TWO);
      assign ch_data[gi]  = mem_reg[rd_ptr_reg];
      assign ch_cnt[gi]   = cnt_reg;
    end
  endgenerate

  assign bus.in_ready   = in_ready;
  assign bus.out1_data  = ch_data[0];
  assign bus.out1_valid = ch_valid[0];
  assign bus.out2_data  = ch_data[1];
  assign bus.out2_valid = ch_valid[1];
  assign bus.cnt1       = ch_cnt[0];
  assign bus.cnt2       = ch_cnt[1];
  assign bus.full1      = ch_full[0];
  assign bus.full2      = ch_full[1];

endmodule

// File: tb/tb_demux2_8_buf.sv
// Directed bench for demux2_8_buf: queue-based reference model compared every
// cycle, plus hand-computed literal expectations at key points.
module tb_demux2_8_buf;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  bit   chk_en;

  demux2_8_buf_if #(.CNT_W(16)) bus ();

  demux2_8_buf #(.DEPTH(2), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: two byte queues capped at 2 entries and two counters.
  logic [7:0]  q1[$];
  logic [7:0]  q2[$];
  logic [15:0] m_cnt1;
  logic [15:0] m_cnt2;

  initial begin
    m_cnt1 = '0;
    m_cnt2 = '0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("m_in_ready", 32'(bus.in_ready),
            32'(!rst && (bus.in_sel ? q2.size() < 2 : q1.size() < 2)));
        chk("m_out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
        chk("m_out2_valid", 32'(bus.out2_valid), 32'(q2.size() != 0));
        chk("m_full1", 32'(bus.full1), 32'(q1.size() == 2));
        chk("m_full2", 32'(bus.full2), 32'(q2.size() == 2));
        chk("m_cnt1", 32'(bus.cnt1), 32'(m_cnt1));
        chk("m_cnt2", 32'(bus.cnt2), 32'(m_cnt2));
        if (q1.size() != 0) chk("m_out1_data", 32'(bus.out1_data), 32'(q1[0]));
        if (q2.size() != 0) chk("m_out2_data", 32'(bus.out2_data), 32'(q2[0]));
      end
      // Advance the model to the state after the coming rising edge.
      if (rst) begin
        q1.delete();
        q2.delete();
        m_cnt1 = '0;
        m_cnt2 = '0;
      end else begin
        bit push1, push2, pop1, pop2;
        push1 = bus.in_valid && !bus.in_sel && q1.size() < 2;
        push2 = bus.in_valid &&  bus.in_sel && q2.size() < 2;
        pop1  = q1.size() != 0 && bus.out1_ready;
        pop2  = q2.size() != 0 && bus.out2_ready;
        if (pop1) begin
          void'(q1.pop_front());
          m_cnt1 = m_cnt1 + 16'd1;
        end
        if (pop2) begin
          void'(q2.pop_front());
          m_cnt2 = m_cnt2 + 16'd1;
        end
        if (push1) q1.push_back(bus.in_data);
        if (push2) q2.push_back(bus.in_data);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    chk_en   = 1'b0;

    // Reset held two cycles with traffic present.
    rst            = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_data    = 8'h55;
    bus.in_sel     = 1'b0;
    bus.out1_ready = 1'b1;
    bus.out2_ready = 1'b1;
    step();
    chk_en = 1'b1;
    chk("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
    step();
    chk("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
    chk("rst_out2_valid", 32'(bus.out2_valid), 32'd0);
    chk("rst_full", 32'({bus.full2, bus.full1}), 32'd0);
    chk("rst_cnt", 32'({bus.cnt2, bus.cnt1}), 32'd0);
    chk("rst_data", 32'({bus.out2_data, bus.out1_data}), 32'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_release_in_ready", 32'(bus.in_ready), 32'd1);
    $display("reset released");

    // Routing.
    bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.in_sel = 1'b0;
    $display("push sel=0 data=a5");
    step();
    chk("route_out1_valid", 32'(bus.out1_valid), 32'd1);
    chk("route_out1_data", 32'(bus.out1_data), 32'hA5);
    chk("route_out2_idle", 32'(bus.out2_valid), 32'd0);
    bus.in_data = 8'h3C; bus.in_sel = 1'b1;
    $display("push sel=1 data=3c");
    step();
    chk("route_out1_drained", 32'(bus.out1_valid), 32'd0);
    chk("route_out2_data", 32'(bus.out2_data), 32'h3C);
    chk("route_cnt1", 32'(bus.cnt1), 32'd1);
    bus.in_valid = 1'b0;
    step();
    chk("route_cnt2", 32'(bus.cnt2), 32'd1);

    // Back-pressure on channel 1, then channel independence.
    bus.out1_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 8'h11;
    $display("push sel=0 data=11");
    step();
    bus.in_data = 8'h22;
    $display("push sel=0 data=22");
    step();
    chk("bp_full1", 32'(bus.full1), 32'd1);
    chk("bp_head", 32'(bus.out1_data), 32'h11);
    bus.in_sel = 1'b1; bus.in_data = 8'h77;
    #1;
    chk("indep_in_ready", 32'(bus.in_ready), 32'd1);
    $display("push sel=1 data=77");
    step();
    chk("indep_out2_data", 32'(bus.out2_data), 32'h77);
    bus.in_valid = 1'b0;
    step();
    chk("indep_cnt2", 32'(bus.cnt2), 32'd2);
    chk("indep_cnt1", 32'(bus.cnt1), 32'd1);
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 8'h33;
    #1;
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    repeat (3) step();
    chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_head", 32'(bus.out1_data), 32'h11);
    bus.out1_ready = 1'b1;
    step();
    chk("bp_second", 32'(bus.out1_data), 32'h22);
    chk("bp_space", 32'(bus.in_ready), 32'd1);
    $display("push sel=0 data=33");
    step();
    chk("bp_third", 32'(bus.out1_data), 32'h33);
    chk("bp_not_full", 32'(bus.full1), 32'd0);
    bus.in_valid = 1'b0;
    step();
    chk("bp_drained", 32'(bus.out1_valid), 32'd0);
    chk("bp_cnt1", 32'(bus.cnt1), 32'd4);

    // Streaming 256 alternating beats from a clean reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = 1'(i);
      bus.in_data  = 8'(i);
      #1;
      chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    chk("stream_cnt1", 32'(bus.cnt1), 32'd128);
    chk("stream_cnt2", 32'(bus.cnt2), 32'd128);
    $display("stream of 256 beats done");

    // Counter wrap on channel 1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b1; bus.in_sel = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      bus.in_data = 8'(i);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    chk("wrap_cnt1_max", 32'(bus.cnt1), 32'hFFFF);
    bus.in_valid = 1'b1; bus.in_data = 8'hEE;
    $display("push sel=0 data=ee");
    step();
    bus.in_valid = 1'b0;
    step();
    chk("wrap_cnt1_zero", 32'(bus.cnt1), 32'd0);

    // Reset with channel 2 full and stalled.
    bus.in_valid = 1'b1; bus.in_sel = 1'b1; bus.in_data = 8'h01;
    $display("push sel=1 data=01");
    step();
    bus.in_valid = 1'b0;
    step();
    chk("mid_cnt2_pre", 32'(bus.cnt2), 32'd1);
    bus.out2_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h02;
    $display("push sel=1 data=02");
    step();
    bus.in_data = 8'h03;
    $display("push sel=1 data=03");
    step();
    chk("mid_full2", 32'(bus.full2), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_out2_valid", 32'(bus.out2_valid), 32'd0);
    chk("mid_cnt2", 32'(bus.cnt2), 32'd0);
    chk("mid_full2_clr", 32'(bus.full2), 32'd0);
    chk("mid_out2_data", 32'(bus.out2_data), 32'd0);
    rst = 1'b0; bus.in_valid = 1'b0; bus.out2_ready = 1'b1;
    step();
    chk("mid_after_valid", 32'(bus.out2_valid), 32'd0);
    chk("mid_after_cnt2", 32'(bus.cnt2), 32'd0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
